// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: measures rising-to-rising period and high time of an async PWM
// input, rounds the duty to tenths and flags a stuck input. Optional glitch filter: PWM_DECODE_FILTER_EN.
module pwm_duty_decoder #(
    parameter logic [19:0] TIMEOUT = 20'd200000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [3:0]  speed,
    output logic [19:0] period,
    output logic [19:0] high_time,
    output logic        valid,
    output logic        stalled
);

    typedef enum logic [1:0] {WAIT_FIRST, MEASURE, COMPUTE} state_t;

    localparam logic [19:0] CNT_MAX  = 20'hFFFFF;
    localparam logic [19:0] STALL_AT = TIMEOUT - 20'd1;
    localparam logic [3:0]  K_MAX    = 4'd10;

    state_t      state, state_nxt;
    logic [1:0]  sync_q;
    logic        sig, sig_d, rise;
    logic [19:0] per_cnt, hi_cnt, idle_cnt;
    logic [19:0] cmp_per, cmp_hi;
    logic [19:0] pend_per, pend_hi;
    logic        pend;
    logic [24:0] acc, h20;
    logic [3:0]  k, k_res;
    logic        hit, full, stall_hit;
    logic        start_cur, start_pend, done, do_stall;

    // ---------------------------------------------------------------
    // Input synchronizer and optional glitch filter
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b00;
        else        sync_q <= {sync_q[0], pwm_in};
    end

`ifdef PWM_DECODE_FILTER_EN
    logic [2:0] hist;
    logic       lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 3'b000;
            lvl  <= 1'b0;
        end else begin
            hist <= {hist[1:0], sync_q[1]};
            lvl  <= sig;
        end
    end

    // Level moves only once the current sample and the three before it agree.
    always_comb begin
        sig = lvl;
        if (&{hist, sync_q[1]})       sig = 1'b1;
        else if (~|{hist, sync_q[1]}) sig = 1'b0;
    end
`else
    assign sig = sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_d <= 1'b0;
        else        sig_d <= sig;
    end

    assign rise = sig & ~sig_d;

    // ---------------------------------------------------------------
    // Duty arithmetic: 20*high against (2k-1)*period, period added twice per step
    // ---------------------------------------------------------------
    assign h20       = {1'b0, cmp_hi, 4'd0} + {3'd0, cmp_hi, 2'd0};
    assign hit       = (h20 >= acc);
    assign full      = (cmp_hi >= cmp_per);
    assign stall_hit = (idle_cnt == STALL_AT);

    always_comb begin
        k_res = k - 4'd1;
        if (full)     k_res = K_MAX;
        else if (hit) k_res = k;
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WAIT_FIRST;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        start_cur  = 1'b0;
        start_pend = 1'b0;
        done       = 1'b0;
        do_stall   = 1'b0;
        case (state)
            WAIT_FIRST: begin
                if (rise)           state_nxt = MEASURE;
                else if (stall_hit) do_stall  = 1'b1;
            end
            MEASURE: begin
                if (pend) begin
                    start_pend = 1'b1;
                    state_nxt  = COMPUTE;
                end else if (rise) begin
                    start_cur = 1'b1;
                    state_nxt = COMPUTE;
                end else if (stall_hit) begin
                    do_stall  = 1'b1;
                    state_nxt = WAIT_FIRST;
                end
            end
            COMPUTE: begin
                if (full || !hit || k == K_MAX) begin
                    done      = 1'b1;
                    state_nxt = MEASURE;
                end
            end
            default: state_nxt = WAIT_FIRST;
        endcase
    end

    // ---------------------------------------------------------------
    // Measurement counters; the edge cycle itself counts as 1 period, 1 high
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt  <= '0;
            hi_cnt   <= '0;
            idle_cnt <= '0;
        end else begin
            if (rise)                    idle_cnt <= '0;
            else if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + 20'd1;

            if (rise) begin
                per_cnt <= 20'd1;
                hi_cnt  <= 20'd1;
            end else if (state != WAIT_FIRST) begin
                if (per_cnt != CNT_MAX)       per_cnt <= per_cnt + 20'd1;
                if (sig && hi_cnt != CNT_MAX) hi_cnt  <= hi_cnt + 20'd1;
            end
        end
    end

    // An edge landing while the divider is busy is snapshotted so its
    // period stays exact; it is processed on the first MEASURE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend     <= 1'b0;
            pend_per <= '0;
            pend_hi  <= '0;
        end else if (rise && (state == COMPUTE || (state == MEASURE && pend))) begin
            pend     <= 1'b1;
            pend_per <= per_cnt;
            pend_hi  <= hi_cnt;
        end else if (start_pend) begin
            pend     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_per <= '0;
            cmp_hi  <= '0;
            acc     <= '0;
            k       <= '0;
        end else if (start_cur) begin
            cmp_per <= per_cnt;
            cmp_hi  <= hi_cnt;
            acc     <= {5'd0, per_cnt};
            k       <= 4'd1;
        end else if (start_pend) begin
            cmp_per <= pend_per;
            cmp_hi  <= pend_hi;
            acc     <= {5'd0, pend_per};
            k       <= 4'd1;
        end else if (state == COMPUTE && !done) begin
            acc     <= acc + {4'd0, cmp_per, 1'b0};
            k       <= k + 4'd1;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            speed     <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stalled   <= 1'b0;
        end else begin
            valid <= done | do_stall;
            if (done) begin
                speed     <= k_res;
                period    <= cmp_per;
                high_time <= cmp_hi;
            end else if (do_stall) begin
                speed     <= sig ? K_MAX : 4'd0;
                period    <= '0;
                high_time <= '0;
                stalled   <= 1'b1;
            end
            if (rise) stalled <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Directed bench for pwm_duty_decoder (TIMEOUT=1000); valid pulses are logged by a
// monitor and compared against hand-computed period/high/speed values.
module tb_pwm_duty_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [3:0]  speed;
    logic [19:0] period, high_time;
    logic        valid, stalled;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int vcount = 0;
    int b, c;

    logic [19:0] r_per [0:63];
    logic [19:0] r_hi  [0:63];
    logic [3:0]  r_spd [0:63];
    logic        r_stl [0:63];
    int          r_lat [0:63];

    pwm_duty_decoder #(.TIMEOUT(20'd1000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pwm_in    (pwm_in),
        .speed     (speed),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .stalled   (stalled)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            if (vcount < 64) begin
                r_per[vcount] = period;
                r_hi[vcount]  = high_time;
                r_spd[vcount] = speed;
                r_stl[vcount] = stalled;
                r_lat[vcount] = cyc - rise_cyc;
            end
            vcount++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rec(input string tag, input int i, input int p, input int h,
                           input int s, input logic st);
        if (i < 0 || i > 63) begin
            check({tag, "_idx"}, i, 0);
        end else begin
            check({tag, "_period"}, r_per[i], p);
            check({tag, "_high"},   r_hi[i],  h);
            check({tag, "_speed"},  r_spd[i], s);
            check({tag, "_stall"},  r_stl[i], st);
        end
    endtask

    task automatic pwm_cycles(input int hi, input int per, input int n);
        for (int j = 0; j < n; j++) begin
            pwm_in   = 1'b1;
            rise_cyc = cyc;
            repeat (hi) @(negedge clk);
            pwm_in   = 1'b0;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_speed",   speed, 0);
        check("rst_period",  period, 0);
        check("rst_high",    high_time, 0);
        check("rst_valid",   valid, 0);
        check("rst_stalled", stalled, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 30/101: first edge silent, each later edge reports
        pwm_cycles(30, 101, 3);
        check("p101_count", vcount, 2);
        chk_rec("p101", 1, 101, 30, 3, 1'b0);
        check("p101_latency_le_11", (r_lat[0] <= 11), 1);

        // near-full duty and half duty at period 901
        pwm_cycles(890, 901, 3);
        check("full_count", vcount, 5);
        chk_rec("full", 4, 901, 890, 10, 1'b0);
        pwm_cycles(450, 901, 2);
        check("half_count", vcount, 7);
        chk_rec("half", 6, 901, 450, 5, 1'b0);
        pwm_cycles(30, 101, 2);
        chk_rec("back101", 8, 101, 30, 3, 1'b0);

        // 2-cycle glitch at offset 60 inside a 30/101 period
        pwm_in = 1'b1; rise_cyc = cyc;
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
        pwm_in = 1'b1;
        repeat (2) @(negedge clk);
        pwm_in = 1'b0;
        repeat (39) @(negedge clk);
        pwm_cycles(30, 101, 1);
`ifdef PWM_DECODE_FILTER_EN
        check("glitch_count", vcount, 11);
        chk_rec("glitch_ignored", 10, 101, 30, 3, 1'b0);
`else
        check("glitch_count", vcount, 12);
        chk_rec("glitch_short", 10, 60, 30, 5, 1'b0);
        chk_rec("glitch_tail", 11, 41, 2, 0, 1'b0);
`endif

        // edge arriving mid-divide, then held high into a stall
        b = vcount;
        pwm_cycles(23, 27, 1);
        pwm_cycles(4, 8, 1);
        pwm_cycles(30, 101, 1);
        pwm_in = 1'b1; rise_cyc = cyc;
        repeat (1500) @(negedge clk);
        check("held_count", vcount, b + 5);
        chk_rec("pend_a", b + 1, 27, 23, 9, 1'b0);
        chk_rec("pend_b", b + 2, 8, 4, 5, 1'b0);
        chk_rec("pend_c", b + 3, 101, 30, 3, 1'b0);
        chk_rec("stall_hi", b + 4, 0, 0, 10, 1'b1);
        check("stall_hi_live", stalled, 1);

        // next rising edge clears stalled, outputs hold
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        pwm_in = 1'b1; rise_cyc = cyc;
        repeat (8) @(negedge clk);
        check("unstall", stalled, 0);
        check("unstall_hold_speed", speed, 10);
        check("unstall_no_valid", vcount, b + 5);

        // constant low -> stall with speed 0
        pwm_in = 1'b0;
        repeat (1100) @(negedge clk);
        check("stall_lo_count", vcount, b + 6);
        chk_rec("stall_lo", b + 5, 0, 0, 0, 1'b1);
        check("stall_lo_live", stalled, 1);

        // reset during COMPUTE aborts the result
        pwm_cycles(30, 101, 2);
        c = vcount;
        check("pre_rst_count", c, b + 7);
        pwm_in = 1'b1; rise_cyc = cyc;
`ifdef PWM_DECODE_FILTER_EN
        repeat (7) @(negedge clk);
`else
        repeat (5) @(negedge clk);
`endif
        rst_n  = 1'b0;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_speed",   speed, 0);
        check("mid_rst_period",  period, 0);
        check("mid_rst_high",    high_time, 0);
        check("mid_rst_valid",   valid, 0);
        check("mid_rst_stalled", stalled, 0);
        check("mid_rst_no_valid", vcount, c);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_no_valid", vcount, c);
        pwm_cycles(30, 101, 1);
        check("post_rst_edge1", vcount, c);
        pwm_cycles(30, 101, 1);
        check("post_rst_edge2", vcount, c + 1);
        chk_rec("post_rst", c, 101, 30, 3, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
